// File: rtl/prng_pkg.sv
// Shared definitions for the PRNG arbiter slice.
//   POLY         - Galois feedback mask for x^16+x^14+x^13+x^11+1
//   DEFAULT_SEED - reset / zero-seed replacement state
//   prng_state_e - arbiter FSM states
//   lfsr_next()  - one right-shift Galois step
package prng_pkg;

  localparam logic [15:0] POLY         = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'h00A3;

  typedef enum logic {
    ST_WARMUP = 1'b0,
    ST_READY  = 1'b1
  } prng_state_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ POLY;
    return n;
  endfunction

endpackage

// File: rtl/prng_lfsr.sv
// 16-bit Galois LFSR state register.
//   clk, rst_n - clock, synchronous active-low reset (state <= SEED)
//   load       - load load_val (an all-zero value is replaced by SEED)
//   load_val   - value to load
//   step       - advance one LFSR step (ignored when load is high)
//   state      - current LFSR state
module prng_lfsr
  import prng_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        step,
  output logic [15:0] state
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= SEED;
    end else if (load) begin
      // The all-zero state locks the LFSR up, so it is never loaded.
      state <= (load_val == 16'h0000) ? SEED : load_val;
    end else if (step) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/prng_arbiter.sv
// Shared-access controller for the 16-bit PRNG.
// Sequences seeding and warm-up, then hands one fresh LFSR value per grant to
// N_REQ requesters in round-robin order.
//   clk, rst_n - clock, synchronous active-low reset
//   req        - per-requester request level
//   seed_load  - single-cycle strobe loading seed into the LFSR
//   seed       - new LFSR state
//   gnt        - one-hot single-cycle grant
//   rn         - random value, valid while rn_valid
//   rn_valid   - high in the cycle gnt is nonzero
//   rn_id      - index of the granted requester
//   busy       - high while warming up (requests ignored)
module prng_arbiter
  import prng_pkg::*;
#(
  parameter int          N_REQ  = 4,
  parameter int          WARMUP = 16,
  parameter logic [15:0] SEED   = DEFAULT_SEED,
  localparam int         IDW    = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             seed_load,
  input  logic [15:0]      seed,
  output logic [N_REQ-1:0] gnt,
  output logic [15:0]      rn,
  output logic             rn_valid,
  output logic [IDW-1:0]   rn_id,
  output logic             busy
);

  localparam logic [7:0]     WARMUP_CNT = 8'(WARMUP);
  localparam logic [IDW-1:0] LAST_INIT  = IDW'(N_REQ - 1);

  prng_state_e      state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [N_REQ-1:0] gnt_d;
  logic [15:0]      rn_d;
  logic             valid_d;
  logic [IDW-1:0]   id_d;

  logic [15:0]      lfsr_state;
  logic             lfsr_load;
  logic             lfsr_step;

  logic             found;
  logic [IDW-1:0]   pick;

  prng_lfsr #(.SEED(SEED)) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (lfsr_load),
    .load_val (seed),
    .step     (lfsr_step),
    .state    (lfsr_state)
  );

  // Round-robin search: first set req bit strictly after last_q, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      int idx;
      idx = (int'(last_q) + k) % N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = IDW'(idx);
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    gnt_d     = '0;
    rn_d      = rn;
    valid_d   = 1'b0;
    id_d      = rn_id;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;

    unique case (state_q)
      ST_WARMUP: begin
        if (seed_load) begin
          lfsr_load = 1'b1;
          cnt_d     = WARMUP_CNT;
        end else if (cnt_q == 8'd0) begin
          state_d = ST_READY;
        end else begin
          lfsr_step = 1'b1;
          cnt_d     = cnt_q - 8'd1;
        end
      end
      ST_READY: begin
        if (seed_load) begin
          lfsr_load = 1'b1;
          cnt_d     = WARMUP_CNT;
          state_d   = ST_WARMUP;
        end else if (found) begin
          lfsr_step   = 1'b1;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          rn_d        = lfsr_next(lfsr_state);
          valid_d     = 1'b1;
          id_d        = pick;
          last_d      = pick;
        end
      end
      default: state_d = ST_WARMUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_WARMUP;
      cnt_q    <= WARMUP_CNT;
      last_q   <= LAST_INIT;
      gnt      <= '0;
      rn       <= 16'h0000;
      rn_valid <= 1'b0;
      rn_id    <= '0;
      busy     <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      gnt      <= gnt_d;
      rn       <= rn_d;
      rn_valid <= valid_d;
      rn_id    <= id_d;
      busy     <= (state_d == ST_WARMUP);
    end
  end

endmodule

// File: doc/prng_arbiter.md
# prng_arbiter

Shared-access controller for the 16-bit pseudo-random number generator. It owns the LFSR state, sequences seeding and warm-up so that no requester ever sees an uninitialised or X state, and shares the generator among N_REQ requesters with a round-robin req/gnt handshake. Each grant delivers one fresh 16-bit value tagged with the requester index.

## Interface
- N_REQ, 4: number of requesters, legal range 2..8.
- WARMUP, 16: LFSR steps discarded after reset or after any seed load, legal range 0..255.
- SEED, 16'h00A3: state loaded at reset; also substituted for any all-zero seed.
- clk  in  1  rising-edge clock; the only clock in the block.
- rst_n  in  1  reset, synchronous and active-low.
- req  in  N_REQ  per-requester request level; held high until the matching gnt bit is seen.
- seed_load  in  1  single-cycle strobe that loads `seed` into the LFSR.
- seed  in  16  new LFSR state, sampled when seed_load is high.
- gnt  out  N_REQ  one-hot, single-cycle grant pulse.
- rn  out  16  random value; valid only while rn_valid is high.
- rn_valid  out  1  high for exactly the cycle gnt is nonzero.
- rn_id  out  $clog2(N_REQ)  index of the granted requester.
- busy  out  1  high while the block is not accepting requests (ST_WARMUP).

## Operation
- LFSR step is a Galois right shift: `lsb = s[0]`, then `s = s >> 1`, then `if (lsb) s ^= 16'hB400`. This realises x^16+x^14+x^13+x^11+1 with period 65535.
- The all-zero state is unreachable. A seed of 16'h0000 loads SEED instead.
- The state machine has two states, ST_WARMUP and ST_READY.
- ST_WARMUP:
  - If the warm-up counter is 0, go to ST_READY with no step.
  - Otherwise step the LFSR and decrement the counter.
  - Requests are ignored.
- ST_READY:
  - If seed_load is high, load the seed, set the counter to WARMUP and go to ST_WARMUP. No grant is issued that cycle.
  - Otherwise, if any req bit is set, pick the first set bit after the last-granted index, wrapping around.
  - On a pick: step the LFSR and register gnt = one-hot(pick), rn = post-step state, rn_valid = 1, rn_id = pick. The last-granted pointer is updated.
- seed_load while in ST_WARMUP reloads the LFSR and restarts the counter at WARMUP. The latest seed always wins.
- A requester holding req after its grant is eligible again; the rotation guarantees fairness. A held req is granted within N_REQ cycles in ST_READY.
- Dropping req before it is granted cancels the request; no state is kept per requester.
- rn is held between grants, but its value is undefined to consumers while rn_valid is 0.

## Timing
- All outputs are registered.
- Reset values: gnt 0, rn 16'h0000, rn_valid 0, rn_id 0, busy 1. Internal state after reset: LFSR = SEED, state ST_WARMUP, counter WARMUP, last-granted pointer N_REQ-1 (so requester 0 is first).
- The first cycle after rst_n rises is warm-up. busy falls after WARMUP+1 edges.
- Latency: req sampled high at edge k in ST_READY produces gnt, rn and rn_valid after edge k. Throughput is one grant per cycle.
- busy tracks the state registered at the same edge.
- rst_n low mid-grant forces the reset values at the next edge and drops any pending grant.
- The seed is sampled only at an edge where seed_load is high. seed_load is ignored during reset.

## Structure
- Package prng_pkg holds: POLY = 16'hB400, DEFAULT_SEED = 16'h00A3, the state enum {ST_WARMUP, ST_READY}, and a function lfsr_next(16-bit) implementing the step.
- Sub-module prng_lfsr contains the 16-bit state register.
  - Inputs: clk, rst_n, load, load_val, step.
  - Output: state.
  - Performs zero-seed substitution on load.
- The arbiter FSM, warm-up counter and round-robin pointer stay in prng_arbiter.

## Test plan
- WARMUP=2, reset, then req=4'b0001 → busy low after 3 edges; first grant gives gnt=0001, rn=16'h7714, rn_id=0. Warm-up steps are 00A3→B451→EE28→7714.
- WARMUP=0, req=4'b0100 held for two grants → rn=16'hB451 then 16'hEE28, rn_id=2 both times, on back-to-back cycles.
- req=4'b1111 held in ST_READY → gnt sequence 0001, 0010, 0100, 1000, 0001; rn_valid is high every cycle.
- seed_load with seed=16'h0000 and WARMUP=0 → LFSR reloads 00A3; the next grant gives rn=16'hB451. A req in the same cycle as seed_load receives no grant that cycle.
- seed_load during ST_WARMUP (WARMUP=4, at count 2) → counter restarts at 4; busy stays high 5 more cycles; no grants occur meanwhile.
- rst_n low for 1 cycle while req=4'b1111 streams grants → all outputs take reset values at the next edge. After release, the sequence restarts from requester 0 with SEED-derived values.
